// File: rtl/psum_acc_sfu.sv
// psum_acc_sfu: multi-pass psum accumulation buffer with ReLU drain; define PSUM_ACC_SAT_EN for saturating adds
module psum_acc_sfu #(
  parameter int col = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_start,
  input  logic [addr_bw-1:0]       cfg_nout,
  input  logic [3:0]               cfg_npass,
  input  logic                     cfg_relu,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [psum_bw*col-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [psum_bw*col-1:0]   out_data,
  output logic                     busy,
  output logic                     done
);
  typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;
  state_t state, state_n;
  logic [addr_bw-1:0] nout, wa, ra;
  logic [3:0] npass, p;
  logic relu;
  logic [psum_bw*col-1:0] mem [2**addr_bw];
  logic [psum_bw*col-1:0] cur, upd, rd, fo;
  logic [psum_bw:0] s;
  logic in_fire, out_fire, last_in, last_out;
  assign in_ready = state == ACC;
  assign out_valid = state == DRAIN;
  assign busy = state != IDLE;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_in = wa == nout && p == npass;
  assign last_out = ra == nout;
  assign cur = mem[wa];
  assign rd = mem[ra];
  assign out_data = state == DRAIN ? fo : '0;
  always_comb begin
    state_n = state == IDLE  ? (cfg_start ? ACC : IDLE) :
              state == ACC   ? (in_fire && last_in ? DRAIN : ACC) :
              state == DRAIN ? (out_fire && last_out ? IDLE : DRAIN) : IDLE;
  end
  // one extra sign bit per channel exposes overflow for the saturating build
  always_comb begin
    upd = '0;
    fo = '0;
    s = '0;
    for (int c = 0; c < col; c++) begin
      s = {cur[c*psum_bw+psum_bw-1], cur[c*psum_bw+:psum_bw]} +
          {in_data[c*psum_bw+psum_bw-1], in_data[c*psum_bw+:psum_bw]};
`ifdef PSUM_ACC_SAT_EN
      upd[c*psum_bw+:psum_bw] = p == 0 ? in_data[c*psum_bw+:psum_bw] :
                                s[psum_bw] ^ s[psum_bw-1] ? {s[psum_bw], {(psum_bw-1){~s[psum_bw]}}} :
                                s[psum_bw-1:0];
`else
      upd[c*psum_bw+:psum_bw] = p == 0 ? in_data[c*psum_bw+:psum_bw] : s[psum_bw-1:0];
`endif
      fo[c*psum_bw+:psum_bw] = relu && rd[c*psum_bw+psum_bw-1] ? '0 : rd[c*psum_bw+:psum_bw];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      nout <= '0;
      npass <= '0;
      relu <= 1'b0;
      wa <= '0;
      ra <= '0;
      p <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      done <= out_fire && last_out;
      if (state == IDLE && cfg_start) begin
        nout <= cfg_nout;
        npass <= cfg_npass;
        relu <= cfg_relu;
        wa <= '0;
        ra <= '0;
        p <= '0;
      end
      if (in_fire) begin
        wa <= wa == nout ? '0 : wa + 1'b1;
        p <= wa == nout ? p + 1'b1 : p;
      end
      if (out_fire) ra <= ra + 1'b1;
    end
  end
  // combinational read plus registered write makes each update visible to the next transfer
  always_ff @(posedge clk) begin
    if (in_fire) mem[wa] <= upd;
  end
endmodule

// File: tb/tb_psum_acc_sfu.sv
// tb_psum_acc_sfu: randomized jobs checked against an arithmetic accumulation model
module tb_psum_acc_sfu;
  localparam int COL = 8, BW = 16, AW = 4, W = COL * BW;
  logic clk = 0, reset = 1, cfg_start = 0, cfg_relu = 0, in_valid = 0, out_ready = 0;
  logic [AW-1:0] cfg_nout = '0;
  logic [3:0] cfg_npass = '0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, busy, done;
  logic [W-1:0] out_data;
  int n_tests = 0, n_fail = 0;
  logic [W-1:0] stim[$];
  logic [W-1:0] exp_q[$];

  psum_acc_sfu #(.col(COL), .psum_bw(BW), .addr_bw(AW)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_nout(cfg_nout),
    .cfg_npass(cfg_npass), .cfg_relu(cfg_relu), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] splat(input logic [BW-1:0] v);
    logic [W-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW+:BW] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW+:BW] = BW'($urandom);
    return r;
  endfunction

  function automatic logic [BW-1:0] add_ch(input logic [BW-1:0] a, input logic [BW-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef PSUM_ACC_SAT_EN
    if (s > (1 << (BW - 1)) - 1) s = (1 << (BW - 1)) - 1;
    if (s < -(1 << (BW - 1))) s = -(1 << (BW - 1));
`endif
    return s[BW-1:0];
  endfunction

  // expected drain: per address, first pass overwrites, later passes add
  task automatic model(input int nout, input bit relu);
    logic [BW-1:0] acc[16][COL];
    logic [W-1:0] v;
    exp_q.delete();
    for (int i = 0; i < stim.size(); i++)
      for (int c = 0; c < COL; c++)
        acc[i % (nout + 1)][c] = i < nout + 1 ? stim[i][c*BW+:BW] :
                                 add_ch(acc[i % (nout + 1)][c], stim[i][c*BW+:BW]);
    for (int a = 0; a <= nout; a++) begin
      for (int c = 0; c < COL; c++) v[c*BW+:BW] = relu && acc[a][c][BW-1] ? '0 : acc[a][c];
      exp_q.push_back(v);
    end
  endtask

  task automatic start(input int nout, input int npass, input bit relu);
    cfg_nout = AW'(nout);
    cfg_npass = 4'(npass);
    cfg_relu = relu;
    cfg_start = 1;
    @(posedge clk); #1;
    cfg_start = 0;
    cfg_nout = AW'($urandom);
    cfg_npass = 4'($urandom);
    cfg_relu = 1'($urandom);
    check("busy_after_start", W'(busy), W'(1));
  endtask

  task automatic send(input logic [W-1:0] v);
    int k = 0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1;
    in_data = v;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    if (k == 50) check("in_ready_timeout", W'(in_ready), W'(1));
    @(posedge clk); #1;
    in_valid = 0;
    in_data = rand_vec();
  endtask

  task automatic poke();
    cfg_nout = AW'($urandom);
    cfg_npass = 4'($urandom);
    cfg_relu = 1'($urandom);
    cfg_start = 1;
    @(posedge clk); #1;
    cfg_start = 0;
  endtask

  task automatic drain(input int stall0);
    logic [W-1:0] held;
    int k;
    for (int i = 0; i < exp_q.size(); i++) begin
      k = 0;
      while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
      if (k == 50) check("out_valid_timeout", W'(out_valid), W'(1));
      check("drain_in_ready", W'(in_ready), W'(0));
      held = out_data;
      repeat (i == 0 ? stall0 : $urandom_range(0, 2)) begin
        @(posedge clk); #1;
        check("stall_valid", W'(out_valid), W'(1));
        check("stall_hold", out_data, held);
      end
      check("out_data", out_data, exp_q[i]);
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
    end
    check("done_pulse", W'(done), W'(1));
    check("idle_busy", W'(busy), W'(0));
    check("idle_out_data", out_data, '0);
  endtask

  task automatic run_job(input int nout, input int npass, input bit relu, input bit do_poke, input int stall0);
    model(nout, relu);
    start(nout, npass, relu);
    for (int i = 0; i < stim.size(); i++) begin
      send(stim[i]);
      if (do_poke && i == 0) poke();
    end
    drain(stall0);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("done_cleared", W'(done), W'(0));
    check("idle_valid", W'(out_valid), W'(0));
  endtask

  initial begin
    logic [W-1:0] v;
    int nout, npass;
    #12;
    check("rst_out_data", out_data, '0);
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    @(posedge clk); #1;
    reset = 0;
    // four single-pass vectors pass through unchanged
    stim = {splat(1), splat(2), splat(3), splat(4)};
    run_job(3, 0, 0, 0, 0);
    idle_cycle();
    // three passes of 5 over two addresses with an ignored mid-job start
    stim = {splat(5), splat(5), splat(5), splat(5), splat(5), splat(5)};
    run_job(1, 2, 0, 1, 0);
    // started in the done cycle; ReLU clips -7, keeps +7; long stall on first output
    stim = {splat(-3), splat(3), splat(-4), splat(4)};
    run_job(1, 1, 1, 0, 5);
    idle_cycle();
    // overflow: saturating build clamps, default build wraps
    stim = {splat(30000), splat(30000)};
    start(0, 1, 0);
    send(stim[0]);
    send(stim[1]);
`ifdef PSUM_ACC_SAT_EN
    exp_q = {splat(32767)};
`else
    exp_q = {splat(-5536)};
`endif
    drain(0);
    idle_cycle();
    // reset mid-accumulation aborts the job
    start(5, 3, 0);
    send(rand_vec());
    send(rand_vec());
    #3 reset = 1;
    #1;
    check("abort_in_ready", W'(in_ready), W'(0));
    check("abort_busy", W'(busy), W'(0));
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_out_data", out_data, '0);
    @(posedge clk); #1;
    reset = 0;
    stim = {rand_vec(), rand_vec(), rand_vec()};
    run_job(0, 2, 1, 0, 1);
    idle_cycle();
    for (int j = 0; j < 20; j++) begin
      nout = $urandom_range(0, 15);
      npass = $urandom_range(0, 3);
      stim.delete();
      for (int i = 0; i < (nout + 1) * (npass + 1); i++) begin
        v = rand_vec();
        if ($urandom_range(0, 1) == 1) for (int c = 0; c < COL; c++) v[c*BW+:BW] = BW'($urandom_range(0, 400)) - BW'(200);
        stim.push_back(v);
      end
      run_job(nout, npass, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/psum_acc_sfu.md
PSUM_ACC_SFU -- requirements
Module: psum_acc_sfu

Interface
REQ-001 SHALL have parameter col, default 8, number of psum channels per vector.
REQ-002 SHALL have parameter psum_bw, default 16, signed two's-complement width of each channel.
REQ-003 SHALL have parameter addr_bw, default 4; internal buffer depth = 2**addr_bw vectors.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cfg_start  input  1  one-cycle pulse that begins a job; sampled only in IDLE.
REQ-007 SHALL have port cfg_nout  input  addr_bw  number of output vectors per pass, minus 1; latched on accepted start.
REQ-008 SHALL have port cfg_npass  input  4  number of accumulation passes, minus 1; latched on accepted start.
REQ-009 SHALL have port cfg_relu  input  1  ReLU enable for the drain phase; latched on accepted start.
REQ-010 SHALL have port in_valid  input  1  input psum vector valid.
REQ-011 SHALL have port in_ready  output  1  block accepts the input vector this cycle.
REQ-012 SHALL have port in_data  input  psum_bw*col  psum vector, channel c at bits [psum_bw*(c+1)-1 : psum_bw*c].
REQ-013 SHALL have port out_valid  output  1  output vector valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the output vector.
REQ-015 SHALL have port out_data  output  psum_bw*col  result vector, same channel packing as in_data.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse in the cycle after the last output handshake.

Function
REQ-018 SHALL implement FSM IDLE -> ACC on cfg_start in IDLE; ACC -> DRAIN on acceptance of the final vector; DRAIN -> IDLE on the final output handshake.
REQ-019 SHALL ignore cfg_start while busy, with no change to latched config or counters.
REQ-020 SHALL drive in_ready = 1 exactly in ACC; an input transfer occurs when in_valid && in_ready.
REQ-021 SHALL maintain write address wa (0..cfg_nout) and pass counter p (0..cfg_npass), both cleared on an accepted start.
REQ-022 SHALL, on each input transfer, write buf[wa] = in_data when p == 0, else buf[wa] = buf[wa] + in_data per channel.
REQ-023 SHALL advance wa on every transfer; at wa == cfg_nout, wrap wa to 0 and increment p; the final vector is wa == cfg_nout && p == cfg_npass.
REQ-024 SHALL make the result of a transfer visible to the next transfer's read of the same address, with no hazard when cfg_nout == 0.
REQ-025 SHALL, in DRAIN, drive out_valid = 1 and out_data = f(buf[ra]) combinationally, with ra starting at 0.
REQ-026 SHALL define f per channel as ReLU (negative -> 0) when latched cfg_relu = 1, otherwise identity.
REQ-027 SHALL advance ra only on out_valid && out_ready, and hold out_data stable while the handshake is stalled.
REQ-028 SHALL assert done for exactly one cycle on return to IDLE, and SHALL accept a cfg_start arriving in that same cycle.
REQ-029 SHALL drive out_valid = 0, in_ready = 0 and out_data = 0 outside DRAIN.

Reset
REQ-030 SHALL, on reset assertion and regardless of clk, force IDLE, clear wa, ra, p and latched config, and drive in_ready = out_valid = busy = done = 0 and out_data = 0.
REQ-031 SHALL abort any in-flight job on reset mid-operation; buffer contents are not cleared and are don't-care after reset.

Configuration
REQ-032 SHALL, with macro PSUM_ACC_SAT_EN defined, saturate each channel addition to [-2**(psum_bw-1), 2**(psum_bw-1)-1]; without the macro, the addition SHALL wrap modulo 2**psum_bw.

Verification
REQ-033 SHALL cover: cfg_nout=3, cfg_npass=0, cfg_relu=0, inputs with all channels = 1,2,3,4 -> outputs 1,2,3,4, then one done pulse.
REQ-034 SHALL cover: cfg_nout=1, cfg_npass=2, all channels = 5 on six inputs -> two outputs of 15; an interleaved cfg_start mid-job is ignored.
REQ-035 SHALL cover: cfg_relu=1, accumulated channel value -7 -> output 0; channel value +7 -> output 7.
REQ-036 SHALL cover: PSUM_ACC_SAT_EN defined, psum_bw=16, 30000 + 30000 -> 32767; macro undefined -> -5536.
REQ-037 SHALL cover: out_ready held low for 5 cycles in DRAIN -> out_valid stays 1, out_data constant, ra unchanged.
REQ-038 SHALL cover: reset pulse mid-ACC -> all outputs 0 immediately, then a fresh job with cfg_nout=0 completes correctly.
